// File: rtl/quad_step_decoder.sv
// Quadrature front end: synchronises and debounces the A/B encoder phases, then
// decodes each accepted Gray-code change into a step pulse, a direction and a position count.
//
// init | meaning
// 0    | no level accepted since reset; the next accepted level only seeds ab_f
// 1    | ab_f holds a trusted reference; accepted changes are decoded into steps
module quad_step_decoder #(
    parameter int CNT_W = 4,
    parameter int FILT  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             A,
    input  logic             B,
    input  logic             clr,
    output logic             step,
    output logic             S,
    output logic [CNT_W-1:0] cnt,
    output logic             Rc,
    output logic             err
);
    localparam int                SC_W    = 4;
    localparam logic [SC_W-1:0]   FILT_SC = SC_W'(FILT);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    logic [1:0]      s1;
    logic [1:0]      s2;
    logic [1:0]      ab_s;
    logic [1:0]      ab_c;
    logic [1:0]      ab_f;
    logic [SC_W-1:0] sc;
    logic            init;
    logic            accept;
    logic [1:0]      idx_new;
    logic [1:0]      idx_old;
    logic [1:0]      delta;

    // Position of a phase pair along the quadrature cycle 00 -> 01 -> 11 -> 10.
    function automatic logic [1:0] gray_idx(input logic [1:0] ab);
        case (ab)
            2'b00:   gray_idx = 2'd0;
            2'b01:   gray_idx = 2'd1;
            2'b11:   gray_idx = 2'd2;
            default: gray_idx = 2'd3;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 2'b00;
            s2 <= 2'b00;
        end else begin
            s1 <= {A, B};
            s2 <= s1;
        end
    end

    assign ab_s = s2;

    // sc counts how long ab_s has matched the candidate; it saturates at FILT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ab_c <= 2'b00;
            sc   <= '0;
        end else if (ab_s != ab_c) begin
            ab_c <= ab_s;
            sc   <= SC_W'(1);
        end else if (sc < FILT_SC) begin
            sc <= sc + SC_W'(1);
        end
    end

    assign accept  = (ab_s == ab_c) && (sc == FILT_SC) && (!init || (ab_c != ab_f));
    assign idx_new = gray_idx(ab_c);
    assign idx_old = gray_idx(ab_f);
    assign delta   = idx_new - idx_old;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ab_f <= 2'b00;
            init <= 1'b0;
        end else if (accept) begin
            ab_f <= ab_c;
            init <= 1'b1;
        end
    end

    // The first accepted level after reset is the encoder's resting position, not motion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step <= 1'b0;
            S    <= 1'b1;
            cnt  <= '0;
            err  <= 1'b0;
        end else begin
            step <= 1'b0;
            if (accept && init) begin
                case (delta)
                    2'd1: begin
                        step <= 1'b1;
                        S    <= 1'b1;
                        cnt  <= cnt + CNT_W'(1);
                    end
                    2'd3: begin
                        step <= 1'b1;
                        S    <= 1'b0;
                        cnt  <= cnt - CNT_W'(1);
                    end
                    2'd2:    err <= 1'b1;
                    default: ;
                endcase
            end
            if (clr) begin
                cnt <= '0;
                err <= 1'b0;
            end
        end
    end

    assign Rc = (S && (cnt == CNT_MAX)) || (!S && (cnt == '0));

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: two instances (FILT=2 and FILT=3) share one stimulus
// and are checked every cycle against a sample-window model, plus literal expectations.
module tb_quad_step_decoder;
    localparam int CNT_W   = 4;
    localparam int FILT_A  = 2;
    localparam int FILT_B  = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic A   = 1'b0;
    logic B   = 1'b0;
    logic clr = 1'b0;

    logic             step_a, S_a, Rc_a, err_a;
    logic [CNT_W-1:0] cnt_a;
    logic             step_b, S_b, Rc_b, err_b;
    logic [CNT_W-1:0] cnt_b;

    int vectors     = 0;
    int miscompares = 0;
    int steps_seen[2];

    // Behavioural model state, index 0 = FILT_A instance, 1 = FILT_B instance.
    int               filt_of[2]   = '{FILT_A, FILT_B};
    int               gray_pos[4]  = '{0, 1, 3, 2};
    logic [1:0]       gray_lv[4]   = '{2'b00, 2'b01, 2'b11, 2'b10};
    logic             m_step[2];
    logic             m_S[2];
    logic             m_err[2];
    logic             m_init[2];
    logic [1:0]       m_abf[2];
    logic [CNT_W-1:0] m_cnt[2];
    logic [1:0]       raw_hist[$];
    logic [1:0]       abs_hist[$];
    int               pos = 0;

    always #5 clk = ~clk;

    quad_step_decoder #(.CNT_W(CNT_W), .FILT(FILT_A)) dut_a (
        .clk(clk), .rst(rst), .A(A), .B(B), .clr(clr),
        .step(step_a), .S(S_a), .cnt(cnt_a), .Rc(Rc_a), .err(err_a)
    );

    quad_step_decoder #(.CNT_W(CNT_W), .FILT(FILT_B)) dut_b (
        .clk(clk), .rst(rst), .A(A), .B(B), .clr(clr),
        .step(step_b), .S(S_b), .cnt(cnt_b), .Rc(Rc_b), .err(err_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        raw_hist.delete();
        abs_hist.delete();
        for (int i = 0; i < 2; i++) begin
            m_step[i] = 1'b0;
            m_S[i]    = 1'b1;
            m_err[i]  = 1'b0;
            m_init[i] = 1'b0;
            m_abf[i]  = 2'b00;
            m_cnt[i]  = '0;
        end
    endtask

    // A level is accepted once the synchronised input has shown it on FILT+1
    // consecutive edges; the synchronised input lags the raw pins by two edges.
    task automatic model_edge(input logic [1:0] ab_in, input logic clr_in);
        int         n;
        int         d;
        logic [1:0] abs_now;
        bit         stable;
        n       = abs_hist.size() + 1;
        abs_now = (n <= 2) ? 2'b00 : raw_hist[n-3];
        raw_hist.push_back(ab_in);
        abs_hist.push_back(abs_now);
        for (int i = 0; i < 2; i++) begin
            stable = (n >= filt_of[i] + 1);
            if (stable)
                for (int j = n - filt_of[i] - 1; j <= n - 1; j++)
                    if (abs_hist[j] != abs_now) stable = 1'b0;
            m_step[i] = 1'b0;
            if (stable && !(m_init[i] && abs_now == m_abf[i])) begin
                if (!m_init[i]) begin
                    m_init[i] = 1'b1;
                end else begin
                    d = (gray_pos[abs_now] - gray_pos[m_abf[i]] + 4) % 4;
                    if (d == 1) begin
                        m_step[i] = 1'b1;
                        m_S[i]    = 1'b1;
                        m_cnt[i]  = m_cnt[i] + 1'b1;
                    end else if (d == 3) begin
                        m_step[i] = 1'b1;
                        m_S[i]    = 1'b0;
                        m_cnt[i]  = m_cnt[i] - 1'b1;
                    end else begin
                        m_err[i] = 1'b1;
                    end
                end
                m_abf[i] = abs_now;
            end
            if (clr_in) begin
                m_cnt[i] = '0;
                m_err[i] = 1'b0;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else      model_edge({A, B}, clr);
        end
    end

    task automatic cmp_inst(input int i, input logic st, input logic s, input logic [CNT_W-1:0] c,
                            input logic rc, input logic e);
        logic exp_rc;
        exp_rc = (m_S[i] && m_cnt[i] == CNT_W'(CNT_MAX)) || (!m_S[i] && m_cnt[i] == '0);
        chk($sformatf("model_step[%0d]", i), st, m_step[i]);
        chk($sformatf("model_S[%0d]", i),    s,  m_S[i]);
        chk($sformatf("model_cnt[%0d]", i),  c,  m_cnt[i]);
        chk($sformatf("model_Rc[%0d]", i),   rc, exp_rc);
        chk($sformatf("model_err[%0d]", i),  e,  m_err[i]);
        if (st === 1'b1) steps_seen[i]++;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cmp_inst(0, step_a, S_a, cnt_a, Rc_a, err_a);
            cmp_inst(1, step_b, S_b, cnt_b, Rc_b, err_b);
        end
    end

    task automatic drive(input logic [1:0] v, input int n);
        {A, B} = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic up(input int hold);
        pos = (pos + 1) % 4;
        drive(gray_lv[pos], hold);
    endtask

    // Step on the FILT_A instance must rise exactly FILT_A+2 edges after s1 captures.
    task automatic lat_step(input logic [1:0] v);
        {A, B} = v;
        for (int j = 0; j <= FILT_A + 3; j++) begin
            @(posedge clk);
            #1;
            chk($sformatf("latency_step_edge%0d", j), step_a, (j == FILT_A + 2));
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        steps_seen[0] = 0;
        steps_seen[1] = 0;
        repeat (3) @(negedge clk);
        chk("reset_step", step_a, 1'b0);
        chk("reset_S",    S_a,    1'b1);
        chk("reset_cnt",  cnt_a,  0);
        chk("reset_Rc",   Rc_a,   1'b0);
        chk("reset_err",  err_a,  1'b0);
        rst = 1'b1;

        drive(2'b00, 10);
        chk("init_steps", steps_seen[0], 0);
        chk("init_cnt",   cnt_a, 0);
        chk("init_Rc",    Rc_a,  1'b0);
        chk("init_err",   err_a, 1'b0);

        for (int k = 1; k <= 4; k++) begin
            pos = k % 4;
            lat_step(gray_lv[pos]);
        end
        chk("fwd_cycle_cnt",   cnt_a, 4);
        chk("fwd_cycle_S",     S_a,   1'b1);
        chk("fwd_cycle_steps", steps_seen[0], 4);

        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_cnt", cnt_a, 0);
        pos = 3;
        drive(gray_lv[pos], 6);
        chk("down_wrap_cnt", cnt_a, 15);
        chk("down_wrap_S",   S_a,   1'b0);
        chk("down_wrap_Rc",  Rc_a,  1'b0);
        for (int k = 0; k < 17; k++) begin
            up(6);
            if (k == 0) begin
                chk("up_wrap_cnt0", cnt_a, 0);
                chk("up_wrap_S",    S_a,   1'b1);
            end
            if (k == 15) begin
                chk("up_cnt15", cnt_a, 15);
                chk("up_Rc15",  Rc_a,  1'b1);
            end
            if (k == 16) begin
                chk("up_wrap_cnt", cnt_a, 0);
                chk("up_wrap_Rc",  Rc_a,  1'b0);
            end
        end

        steps_seen[0] = 0;
        steps_seen[1] = 0;
        drive(gray_lv[pos] ^ 2'b10, 1);
        drive(gray_lv[pos], 8);
        chk("glitch1_steps_a", steps_seen[0], 0);
        chk("glitch1_steps_b", steps_seen[1], 0);
        drive(gray_lv[pos] ^ 2'b10, FILT_B - 1);
        drive(gray_lv[pos], 8);
        chk("glitch2_steps_b", steps_seen[1], 0);
        chk("glitch2_cnt_b",   cnt_b, 0);
        drive(gray_lv[pos] ^ 2'b10, FILT_B + 1);
        drive(gray_lv[pos], 8);
        chk("pulse_steps_b", steps_seen[1], 2);
        chk("pulse_cnt_b",   cnt_b, 0);

        steps_seen[0] = 0;
        pos = (pos + 2) % 4;
        drive(gray_lv[pos], 8);
        chk("jump_err",   err_a, 1'b1);
        chk("jump_steps", steps_seen[0], 0);
        chk("jump_cnt",   cnt_a, 0);

        pos = (pos + 1) % 4;
        {A, B} = gray_lv[pos];
        repeat (FILT_A + 2) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        chk("clr_step_step", step_a, 1'b1);
        chk("clr_step_S",    S_a,    1'b1);
        chk("clr_step_cnt",  cnt_a,  0);
        chk("clr_step_err",  err_a,  1'b0);
        @(negedge clk);
        clr = 1'b0;
        repeat (6) @(negedge clk);

        for (int k = 0; k < 6; k++) up(6);
        pos = (pos + 2) % 4;
        drive(gray_lv[pos], 8);
        chk("pre_rst_cnt", cnt_a, 6);
        chk("pre_rst_err", err_a, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_step", step_a, 1'b0);
        chk("midrst_S",    S_a,    1'b1);
        chk("midrst_cnt",  cnt_a,  0);
        chk("midrst_Rc",   Rc_a,   1'b0);
        chk("midrst_err",  err_a,  1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        steps_seen[0] = 0;
        drive(gray_lv[pos], 10);
        chk("post_rst_steps", steps_seen[0], 0);
        chk("post_rst_cnt",   cnt_a, 0);
        up(8);
        chk("post_rst_up_cnt", cnt_a, 1);
        chk("post_rst_up_S",   S_a,   1'b1);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
